// File: rtl/ysyx_22051468_issue_ctrl_pkg.sv
// rtl/ysyx_22051468_issue_ctrl_pkg.sv - shared INST_TYPE constants for the issue controller
package ysyx_22051468_issue_ctrl_pkg;

  localparam int GPR_NUM = 32;
  localparam int GPR_AW  = 5;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_MD_WAIT = 1'b1;

endpackage

// File: rtl/ysyx_22051468_issue_ctrl_scoreboard.sv
// rtl/ysyx_22051468_issue_ctrl_scoreboard.sv - GPR pending-write scoreboard with hazard lookup
// Optional macro YSYX_22051468_ISSUE_BYPASS_EN: lookup sees the same-cycle retire clear.
module ysyx_22051468_Scoreboard
  import ysyx_22051468_issue_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [GPR_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [GPR_AW-1:0] clr_addr,
  input  logic [GPR_AW-1:0] rs1_addr,
  input  logic [GPR_AW-1:0] rs2_addr,
  input  logic [GPR_AW-1:0] rd_addr,
  input  logic              rs1_need,
  input  logic              rs2_need,
  input  logic              rd_need,
  output logic              hazard
);

  logic [GPR_NUM-1:0] pend;
  logic [GPR_NUM-1:0] pend_nxt;
  logic [GPR_NUM-1:0] pend_view;
  logic [GPR_NUM-1:0] set_mask;
  logic [GPR_NUM-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_addr] = 1'b1;
    if (clr_en) clr_mask[clr_addr] = 1'b1;
    // set is applied after clear so a same-register collision leaves the bit set; x0 never pends
    pend_nxt = ((pend & ~clr_mask) | set_mask) & {{(GPR_NUM-1){1'b1}}, 1'b0};
`ifdef YSYX_22051468_ISSUE_BYPASS_EN
    pend_view = pend & ~clr_mask;
`else
    pend_view = pend;
`endif
    hazard = (rs1_need & pend_view[rs1_addr]) |
             (rs2_need & pend_view[rs2_addr]) |
             (rd_need  & pend_view[rd_addr]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_nxt;
  end

endmodule

// File: rtl/ysyx_22051468_issue_ctrl.sv
// rtl/ysyx_22051468_issue_ctrl.sv - in-order issue control: scoreboard, MD wait FSM, stall counter
// Optional macro YSYX_22051468_ISSUE_BYPASS_EN: retire and md_done forward into the same-cycle issue decision.
module ysyx_22051468_issue_ctrl
  import ysyx_22051468_issue_ctrl_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid_i,
  output logic                   id_ready_o,
  input  logic [GPR_AW-1:0]      rs1_addr_i,
  input  logic [GPR_AW-1:0]      rs2_addr_i,
  input  logic [GPR_AW-1:0]      rd_addr_i,
  input  logic                   rs1_need_i,
  input  logic                   rs2_need_i,
  input  logic                   rd_need_i,
  input  logic                   is_mul_i,
  input  logic                   is_div_i,
  input  logic                   is_rem_i,
  output logic                   ex_valid_o,
  input  logic                   ex_ready_i,
  input  logic                   wb_valid_i,
  input  logic [GPR_AW-1:0]      wb_rd_addr_i,
  input  logic                   md_done_i,
  input  logic                   flush_i,
  output logic [STALL_CNT_W-1:0] stall_cnt_o,
  output logic                   busy_o
);

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic       hazard;
  logic       md_ok;
  logic       issue;
  logic       is_md;
  logic       set_en;
  logic       clr_en;

  ysyx_22051468_Scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (set_en),
    .set_addr (rd_addr_i),
    .clr_en   (clr_en),
    .clr_addr (wb_rd_addr_i),
    .rs1_addr (rs1_addr_i),
    .rs2_addr (rs2_addr_i),
    .rd_addr  (rd_addr_i),
    .rs1_need (rs1_need_i),
    .rs2_need (rs2_need_i),
    .rd_need  (rd_need_i),
    .hazard   (hazard)
  );

  always_comb begin
`ifdef YSYX_22051468_ISSUE_BYPASS_EN
    md_ok = (state == ST_RUN) | ((state == ST_MD_WAIT) & md_done_i);
`else
    md_ok = (state == ST_RUN);
`endif
    is_md  = is_mul_i | is_div_i | is_rem_i;
    issue  = id_valid_i & ex_ready_i & ~hazard & ~flush_i & md_ok;
    set_en = issue & rd_need_i & (rd_addr_i != '0);
    clr_en = wb_valid_i & (wb_rd_addr_i != '0);

    // a new MD op issued in the completion cycle must re-enter the wait
    state_nxt = state;
    if ((state == ST_MD_WAIT) && md_done_i) state_nxt = ST_RUN;
    if (issue && is_md)                     state_nxt = ST_MD_WAIT;
  end

  assign ex_valid_o = issue;
  assign id_ready_o = issue | (id_valid_i & flush_i);
  assign busy_o     = (state == ST_MD_WAIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      stall_cnt_o <= '0;
    end else begin
      state <= state_nxt;
      if (id_valid_i && !issue && !flush_i && !(&stall_cnt_o))
        stall_cnt_o <= stall_cnt_o + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_ysyx_22051468_issue_ctrl.sv
// tb/tb_ysyx_22051468_issue_ctrl.sv - self-checking bench for the issue controller
module tb_ysyx_22051468_issue_ctrl;

`ifdef YSYX_22051468_ISSUE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct {
    logic v, er, fl;
    logic [4:0] rs1; logic n1;
    logic [4:0] rs2; logic n2;
    logic [4:0] rd;  logic nd;
    logic md;
    logic wbv; logic [4:0] wbrd;
    logic ex, rdy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_ready, rs1_need, rs2_need, rd_need;
  logic [4:0] rs1_addr, rs2_addr, rd_addr, wb_rd_addr;
  logic is_mul, is_div, is_rem, ex_valid, ex_ready, wb_valid, md_done, flush, busy;
  logic [31:0] stall_cnt;
  logic id_valid2, id_ready2, ex_valid2, busy2;
  logic [3:0] stall_cnt2;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  logic [1:0] exp_q[$];
  logic [1:0] got;
  vec_t tbl[15];

  always #5 clk = ~clk;

  ysyx_22051468_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_ready_o(id_ready),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr), .rd_addr_i(rd_addr),
    .rs1_need_i(rs1_need), .rs2_need_i(rs2_need), .rd_need_i(rd_need),
    .is_mul_i(is_mul), .is_div_i(is_div), .is_rem_i(is_rem),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready), .wb_valid_i(wb_valid),
    .wb_rd_addr_i(wb_rd_addr), .md_done_i(md_done), .flush_i(flush),
    .stall_cnt_o(stall_cnt), .busy_o(busy)
  );

  ysyx_22051468_issue_ctrl #(.STALL_CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid2), .id_ready_o(id_ready2),
    .rs1_addr_i(5'd0), .rs2_addr_i(5'd0), .rd_addr_i(5'd0),
    .rs1_need_i(1'b0), .rs2_need_i(1'b0), .rd_need_i(1'b0),
    .is_mul_i(1'b0), .is_div_i(1'b0), .is_rem_i(1'b0),
    .ex_valid_o(ex_valid2), .ex_ready_i(1'b0), .wb_valid_i(1'b0),
    .wb_rd_addr_i(5'd0), .md_done_i(1'b0), .flush_i(1'b0),
    .stall_cnt_o(stall_cnt2), .busy_o(busy2)
  );

  function automatic vec_t mk(input logic v, er, fl, input logic [4:0] rs1, input logic n1,
                              input logic [4:0] rs2, input logic n2, input logic [4:0] rd,
                              input logic nd, md, wbv, input logic [4:0] wbrd,
                              input logic ex, rdy);
    vec_t t;
    t.v = v; t.er = er; t.fl = fl; t.rs1 = rs1; t.n1 = n1; t.rs2 = rs2; t.n2 = n2;
    t.rd = rd; t.nd = nd; t.md = md; t.wbv = wbv; t.wbrd = wbrd; t.ex = ex; t.rdy = rdy;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    id_valid = t.v; ex_ready = t.er; flush = t.fl;
    rs1_addr = t.rs1; rs1_need = t.n1; rs2_addr = t.rs2; rs2_need = t.n2;
    rd_addr = t.rd; rd_need = t.nd; is_div = t.md; is_mul = 1'b0; is_rem = 1'b0;
    wb_valid = t.wbv; wb_rd_addr = t.wbrd; md_done = 1'b0;
  endtask

  task automatic idle();
    apply(mk(0,0,0, 5'd0,0, 5'd0,0, 5'd0,0, 0, 0,5'd0, 0,0));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // issue rd=5, RAW stall, flush, retire, x0, ex_ready low, WAW collision on x7
    tbl[0]  = mk(1,1,0, 5'd0,0, 5'd0,0, 5'd5,1, 0, 0,5'd0, 1,1);
    tbl[1]  = mk(1,1,0, 5'd5,1, 5'd0,0, 5'd0,0, 0, 0,5'd0, 0,0);
    tbl[2]  = mk(1,1,1, 5'd5,1, 5'd0,0, 5'd0,0, 0, 0,5'd0, 0,1);
    tbl[3]  = mk(1,1,0, 5'd5,1, 5'd0,0, 5'd0,0, 0, 1,5'd5, BYP,BYP);
    tbl[4]  = mk(1,1,0, 5'd5,1, 5'd0,0, 5'd0,0, 0, 0,5'd0, 1,1);
    tbl[5]  = mk(1,1,0, 5'd0,0, 5'd0,0, 5'd0,1, 0, 0,5'd0, 1,1);
    tbl[6]  = mk(1,1,0, 5'd0,1, 5'd0,1, 5'd0,1, 0, 0,5'd0, 1,1);
    tbl[7]  = mk(1,0,0, 5'd1,1, 5'd2,1, 5'd3,1, 0, 0,5'd0, 0,0);
    tbl[8]  = mk(0,1,0, 5'd1,1, 5'd2,1, 5'd3,1, 0, 0,5'd0, 0,0);
    tbl[9]  = mk(1,1,0, 5'd0,0, 5'd0,0, 5'd7,1, 0, 1,5'd7, 1,1);
    tbl[10] = mk(1,1,0, 5'd0,0, 5'd7,1, 5'd0,0, 0, 0,5'd0, 0,0);
    tbl[11] = mk(1,1,0, 5'd0,0, 5'd0,0, 5'd7,1, 0, 0,5'd0, 0,0);
    tbl[12] = mk(0,1,0, 5'd0,0, 5'd0,0, 5'd0,0, 0, 1,5'd7, 0,0);
    tbl[13] = mk(1,1,0, 5'd0,0, 5'd0,0, 5'd7,1, 0, 0,5'd0, 1,1);
    tbl[14] = mk(0,0,0, 5'd0,0, 5'd0,0, 5'd0,0, 0, 1,5'd7, 0,0);

    rst_n = 1'b0; id_valid2 = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_cnt", stall_cnt, 0);
    chk("reset_cnt_sat", {28'd0, stall_cnt2}, 0);
    chk("reset_ex_valid", {31'd0, ex_valid}, 0);
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i]);
      exp_q.push_back({tbl[i].ex, tbl[i].rdy});
      if (tbl[i].v && !tbl[i].ex && !tbl[i].fl) exp_cnt++;
      #1;
      got = exp_q.pop_front();
      chk($sformatf("vec%0d_ex_valid", i), {31'd0, ex_valid}, {31'd0, got[1]});
      chk($sformatf("vec%0d_id_ready", i), {31'd0, id_ready}, {31'd0, got[0]});
      step();
    end
    idle();
    #1;
    chk("table_stall_cnt", stall_cnt, exp_cnt);

    // md_done in RUN must not disturb anything
    md_done = 1'b1;
    step();
    md_done = 1'b0;
    #1;
    chk("md_done_in_run_busy", {31'd0, busy}, 0);

    // divide rd=3, then an independent op waits out the MD unit
    apply(mk(1,1,0, 5'd0,0, 5'd0,0, 5'd3,1, 1, 0,5'd0, 1,1));
    #1;
    chk("md_issue_ex_valid", {31'd0, ex_valid}, 1);
    step();
    apply(mk(1,1,0, 5'd1,1, 5'd2,1, 5'd4,1, 0, 0,5'd0, 0,0));
    #1;
    chk("md_busy_set", {31'd0, busy}, 1);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("md_wait%0d_ex_valid", k), {31'd0, ex_valid}, 0);
      exp_cnt++;
      step();
    end
    md_done = 1'b1;
    #1;
    chk("md_done_cycle_ex_valid", {31'd0, ex_valid}, {31'd0, BYP});
    if (!BYP) exp_cnt++;
    step();
    md_done = 1'b0;
    rd_need = 1'b0;
    #1;
    chk("md_busy_clear", {31'd0, busy}, 0);
    chk("md_resume_ex_valid", {31'd0, ex_valid}, 1);
    step();
    idle();
    wb_valid = 1'b1; wb_rd_addr = 5'd3;
    #1;
    chk("md_stall_cnt", stall_cnt, exp_cnt);
    step();

    // reset while in MD_WAIT with x9 pending
    apply(mk(1,1,0, 5'd0,0, 5'd0,0, 5'd9,1, 1, 0,5'd0, 1,1));
    #1;
    chk("rst_md_issue", {31'd0, ex_valid}, 1);
    step();
    idle();
    #1;
    chk("rst_pre_busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_cnt", stall_cnt, 0);
    apply(mk(1,1,0, 5'd9,1, 5'd0,0, 5'd9,1, 0, 0,5'd0, 1,1));
    #1;
    chk("rst_pend_cleared", {31'd0, ex_valid}, 1);
    step();
    idle();

    // 4-bit counter saturates
    id_valid2 = 1'b1;
    repeat (20) step();
    #1;
    chk("sat_cnt", {28'd0, stall_cnt2}, 15);
    chk("sat_ex_valid", {31'd0, ex_valid2}, 0);
    chk("sat_id_ready", {31'd0, id_ready2}, 0);
    chk("sat_busy", {31'd0, busy2}, 0);
    id_valid2 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22051468_issue_ctrl.md
YSYX_22051468_ISSUE_CTRL -- requirements
Module: ysyx_22051468_issue_ctrl

Interface
REQ-001 SHALL have parameter STALL_CNT_W, default 32: width of the saturating stall counter.
REQ-002 SHALL have port clk  in  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  synchronous, active-low reset.
REQ-004 SHALL have port id_valid_i  in  1  decoded instruction present at the decode stage.
REQ-005 SHALL have port id_ready_o  out  1  decode-stage instruction consumed this cycle.
REQ-006 SHALL have ports rs1_addr_i, rs2_addr_i, rd_addr_i  in  5 each  GPR addresses from decode.
REQ-007 SHALL have ports rs1_need_i, rs2_need_i, rd_need_i  in  1 each  operand/destination usage flags.
REQ-008 SHALL have ports is_mul_i, is_div_i, is_rem_i  in  1 each  multi-cycle (MD) class flags.
REQ-009 SHALL have port ex_valid_o  out  1  issue strobe to execute.
REQ-010 SHALL have port ex_ready_i  in  1  execute accepts an instruction.
REQ-011 SHALL have ports wb_valid_i  in  1 and wb_rd_addr_i  in  5  register writeback retire.
REQ-012 SHALL have port md_done_i  in  1  MD unit completion pulse.
REQ-013 SHALL have port flush_i  in  1  control redirect; discard the decode-stage instruction.
REQ-014 SHALL have port stall_cnt_o  out  STALL_CNT_W  stall-cycle count.
REQ-015 SHALL have port busy_o  out  1  high in state MD_WAIT.

Function
REQ-016 SHALL keep a 32-bit pending scoreboard, one bit per GPR; bit 0 is constant 0.
REQ-017 SHALL define hazard = (rs1_need_i & pend[rs1]) | (rs2_need_i & pend[rs2]) | (rd_need_i & pend[rd]) (WAW included).
REQ-018 SHALL define issue = id_valid_i & ex_ready_i & ~hazard & ~flush_i & (state==RUN); combinational, zero-cycle latency.
REQ-019 SHALL drive ex_valid_o = issue and id_ready_o = issue | (id_valid_i & flush_i).
REQ-020 SHALL set pend[rd_addr_i] on issue when rd_need_i=1 and rd_addr_i!=0.
REQ-021 SHALL clear pend[wb_rd_addr_i] when wb_valid_i=1.
REQ-022 SHALL give set priority over clear when both target the same register in the same cycle.
REQ-023 SHALL implement FSM RUN -> MD_WAIT on issue with is_mul_i|is_div_i|is_rem_i.
REQ-024 SHALL implement FSM MD_WAIT -> RUN on md_done_i; in MD_WAIT, issue is 0.
REQ-025 SHALL not cancel in-flight instructions on flush_i; scoreboard and FSM are unaffected by flush_i.
REQ-026 SHALL increment stall_cnt_o by 1 each cycle with id_valid_i & ~issue & ~flush_i, saturating at all-ones.
REQ-027 SHALL ignore md_done_i in RUN and ignore wb_valid_i with wb_rd_addr_i=0.

Reset
REQ-028 SHALL, on clk edge with rst_n=0, set pend=0, state=RUN, stall_cnt_o=0; combinational outputs follow, so ex_valid_o/id_ready_o depend only on inputs.
REQ-029 SHALL discard an MD_WAIT or pending bits when reset asserts mid-operation; no retire is required afterwards.

Configuration
REQ-030 SHALL honour macro YSYX_22051468_ISSUE_BYPASS_EN.
REQ-031 With YSYX_22051468_ISSUE_BYPASS_EN defined, hazard SHALL use pend masked by the same-cycle wb clear, and MD_WAIT SHALL allow issue in the md_done_i cycle.
REQ-032 Without YSYX_22051468_ISSUE_BYPASS_EN, hazard and FSM SHALL use registered values only: one extra stall cycle after retire.

Structure
REQ-033 SHALL place the state encoding (RUN=0, MD_WAIT=1) and GPR count/address width constants in the shared INST_TYPE define file.
REQ-034 SHALL instantiate one sub-module ysyx_22051468_Scoreboard (pend storage, set/clear, hazard lookup); FSM and counter stay in the top.

Verification
REQ-035 SHALL cover RAW: issue rd=5; next rs1=5 -> ex_valid_o=0, stall_cnt_o +1 per cycle; wb_rd=5 -> issue same cycle (BYPASS_EN) or next cycle (without).
REQ-036 SHALL cover x0: rd=0 issued, then rs1=0,rs2=0 consumer -> issues back-to-back, pend stays 0.
REQ-037 SHALL cover MD: issue is_div_i -> busy_o=1; independent instruction stalls; md_done_i after 10 cycles -> busy_o=0, issue resumes.
REQ-038 SHALL cover collision: wb_rd=7 and issue rd=7 same cycle -> pend[7]=1 afterwards.
REQ-039 SHALL cover flush: hazarded instruction + flush_i=1 -> id_ready_o=1, ex_valid_o=0, stall_cnt_o unchanged, pend unchanged.
REQ-040 SHALL cover saturation and reset: STALL_CNT_W=4, 20 stall cycles -> stall_cnt_o=15; rst_n=0 in MD_WAIT -> next cycle state RUN, pend=0.
